// File: rtl/hex_entry_pkg.sv
// Shared types and sizing for the front-panel hex digit entry unit.
package hex_entry_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;
   localparam int CURSOR_W   = $clog2(NUM_DIGITS);

   // Debouncer states: a level must stay put for a full count before it is believed.
   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } debounce_state_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes one raw active-low button and debounces it, producing a single
// press pulse per accepted press (no auto-repeat while held).
module key_debounce
   import hex_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn_n,
   output logic o_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic            r_sync1;
   logic            r_sync2;
   debounce_state_t r_state;
   debounce_state_t w_stateNext;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;

   // Two-flop synchronizer; resets to the released level so a held button
   // still has to be seen low after reset and debounced from scratch.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_btn_n;
         r_sync2 <= r_sync1;
      end
   end

   // Debouncer state and stability counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= RELEASED;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
      end
   end

   // Next-state logic: count stable samples, fall back on any bounce, and
   // fire the press pulse on the PRESS_WAIT -> PRESSED transition only.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      o_press     = 1'b0;
      case (r_state)
         RELEASED: begin
            if (!r_sync2) begin
               w_stateNext = PRESS_WAIT;
               w_cntNext   = '0;
            end
         end
         PRESS_WAIT: begin
            if (r_sync2) begin
               w_stateNext = RELEASED;
            end else if (r_cnt == CNT_LAST) begin
               w_stateNext = PRESSED;
               o_press     = 1'b1;
            end else begin
               w_cntNext = r_cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (r_sync2) begin
               w_stateNext = RELEASE_WAIT;
               w_cntNext   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!r_sync2) begin
               w_stateNext = PRESSED;
            end else if (r_cnt == CNT_LAST) begin
               w_stateNext = RELEASED;
            end else begin
               w_cntNext = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_stateNext = RELEASED;
            w_cntNext   = '0;
         end
      endcase
   end

endmodule

// File: rtl/hex_entry.sv
// Front-panel 4-digit hex entry: three debounced buttons edit one nibble at a
// time, a blink mask flags the selected digit, and commit publishes the value.
module hex_entry
   import hex_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int BLINK_CYCLES    = 12_500_000
)(
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic                btn_next_n,
   input  logic                btn_inc_n,
   input  logic                btn_commit_n,
   output logic [VALUE_W-1:0]  value,
   output logic [CURSOR_W-1:0] cursor,
   output logic [NUM_DIGITS-1:0] blank,
   output logic [VALUE_W-1:0]  committed,
   output logic                commit_valid
);

   localparam int BL_W = $clog2(BLINK_CYCLES);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

   logic w_incPress;
   logic w_nextPress;
   logic w_commitPress;

   logic [VALUE_W-1:0]    r_value;
   logic [VALUE_W-1:0]    w_valueNext;
   logic [CURSOR_W-1:0]   r_cursor;
   logic [VALUE_W-1:0]    r_committed;
   logic                  r_commitValid;
   logic [BL_W-1:0]       r_blinkCnt;
   logic                  r_phase;
   logic [NUM_DIGITS-1:0] w_blank;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_incKey (
      .i_clk   (CLOCK_50),
      .i_rst_n (resetn),
      .i_btn_n (btn_inc_n),
      .o_press (w_incPress)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nextKey (
      .i_clk   (CLOCK_50),
      .i_rst_n (resetn),
      .i_btn_n (btn_next_n),
      .o_press (w_nextPress)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commitKey (
      .i_clk   (CLOCK_50),
      .i_rst_n (resetn),
      .i_btn_n (btn_commit_n),
      .o_press (w_commitPress)
   );

   // Increment only the nibble under the current cursor; no carry between digits.
   always_comb begin
      w_valueNext = r_value;
      if (w_incPress) begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_cursor == CURSOR_W'(d)) begin
               w_valueNext[d*DIGIT_W +: DIGIT_W] = r_value[d*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
            end
         end
      end
   end

   // Edit registers: all events in one cycle see pre-edge value and cursor.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_value       <= '0;
         r_cursor      <= '0;
         r_committed   <= '0;
         r_commitValid <= 1'b0;
      end else begin
         r_value       <= w_valueNext;
         r_commitValid <= w_commitPress;
         if (w_nextPress) begin
            r_cursor <= r_cursor + CURSOR_W'(1);
         end
         if (w_commitPress) begin
            r_committed <= r_value;
         end
      end
   end

   // Blink generator; an edit restarts it in the visible phase.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_blinkCnt <= '0;
         r_phase    <= 1'b0;
      end else if (w_incPress || w_nextPress) begin
         r_blinkCnt <= '0;
         r_phase    <= 1'b0;
      end else if (r_blinkCnt == BL_LAST) begin
         r_blinkCnt <= '0;
         r_phase    <= ~r_phase;
      end else begin
         r_blinkCnt <= r_blinkCnt + BL_W'(1);
      end
   end

   // Blank mask: only the selected digit is blanked, and only in the off phase.
   always_comb begin
      w_blank = '0;
      if (r_phase) begin
         w_blank[r_cursor] = 1'b1;
      end
   end

   assign value        = r_value;
   assign cursor       = r_cursor;
   assign blank        = w_blank;
   assign committed    = r_committed;
   assign commit_valid = r_commitValid;

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry with short debounce and blink periods.
module tb_hex_entry;

   localparam int DC = 4;
   localparam int BC = 8;

   logic        CLOCK_50 = 1'b0;
   logic        resetn;
   logic        btnNextN;
   logic        btnIncN;
   logic        btnCommitN;
   logic [15:0] value;
   logic [1:0]  cursor;
   logic [3:0]  blank;
   logic [15:0] committed;
   logic        commit_valid;

   int testsRun    = 0;
   int testsFailed = 0;

   hex_entry #(.DEBOUNCE_CYCLES(DC), .BLINK_CYCLES(BC)) dut (
      .CLOCK_50     (CLOCK_50),
      .resetn       (resetn),
      .btn_next_n   (btnNextN),
      .btn_inc_n    (btnIncN),
      .btn_commit_n (btnCommitN),
      .value        (value),
      .cursor       (cursor),
      .blank        (blank),
      .committed    (committed),
      .commit_valid (commit_valid)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Reference model: buttons judged by run lengths of raw samples, events
   // landing two edges after acceptance, digits kept as a plain array.
   int       mDigit [4];
   int       mCursor;
   int       mCommitted;
   bit       mCommitValid;
   int       mK;
   int       lowRun [3];
   int       highRun [3];
   bit       armed [3];
   bit [2:0] pipe1;
   bit [2:0] pipe2;
   bit [2:0] mEv;
   bit [2:0] mDet;
   bit [2:0] mRaw;

   function automatic logic [15:0] mValue();
      return 16'(mDigit[3] * 4096 + mDigit[2] * 256 + mDigit[1] * 16 + mDigit[0]);
   endfunction

   function automatic logic [3:0] mBlank();
      if (((mK / BC) % 2) == 1) return 4'(1 << mCursor);
      return 4'b0000;
   endfunction

   // Model update at each rising edge; index 0 = inc, 1 = next, 2 = commit.
   always @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         for (int b = 0; b < 4; b++) mDigit[b] = 0;
         for (int b = 0; b < 3; b++) begin
            lowRun[b]  = 0;
            highRun[b] = 0;
            armed[b]   = 1'b1;
         end
         mCursor = 0; mCommitted = 0; mCommitValid = 1'b0; mK = 0;
         pipe1 = '0; pipe2 = '0;
      end else begin
         mEv = pipe2;
         mCommitValid = mEv[2];
         if (mEv[2]) mCommitted = int'(mValue());
         if (mEv[0]) mDigit[mCursor] = (mDigit[mCursor] + 1) % 16;
         if (mEv[1]) mCursor = (mCursor + 1) % 4;
         if (mEv[0] || mEv[1]) mK = 0;
         else mK = mK + 1;
         pipe2 = pipe1;
         mRaw = {btnCommitN, btnNextN, btnIncN};
         mDet = '0;
         for (int b = 0; b < 3; b++) begin
            if (!mRaw[b]) begin
               lowRun[b]++;
               highRun[b] = 0;
               if (armed[b] && lowRun[b] == DC + 1) begin
                  mDet[b]  = 1'b1;
                  armed[b] = 1'b0;
               end
            end else begin
               highRun[b]++;
               lowRun[b] = 0;
               if (!armed[b] && highRun[b] == DC + 1) armed[b] = 1'b1;
            end
         end
         pipe1 = mDet;
      end
   end

   task automatic applyReset();
      @(negedge CLOCK_50);
      btnIncN = 1'b1; btnNextN = 1'b1; btnCommitN = 1'b1;
      resetn = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      resetn = 1'b1;
      repeat (2) @(negedge CLOCK_50);
   endtask

   // mask bit 0 = inc, 1 = next, 2 = commit
   task automatic pressKeys(input logic [2:0] mask, input int hold, input int gap);
      @(negedge CLOCK_50);
      if (mask[0]) btnIncN = 1'b0;
      if (mask[1]) btnNextN = 1'b0;
      if (mask[2]) btnCommitN = 1'b0;
      repeat (hold) @(negedge CLOCK_50);
      btnIncN = 1'b1; btnNextN = 1'b1; btnCommitN = 1'b1;
      repeat (gap) @(negedge CLOCK_50);
   endtask

   task automatic test_reset();
      @(negedge CLOCK_50);
      resetn = 1'b0;
      btnIncN = 1'b1; btnNextN = 1'b1; btnCommitN = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      testsRun++;
      if (value !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_value got %h want 0000", value); end
      testsRun++;
      if (committed !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_committed got %h want 0000", committed); end
      testsRun++;
      if (cursor !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_cursor got %0d want 0", cursor); end
      testsRun++;
      if (blank !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_blank got %b want 0000", blank); end
      testsRun++;
      if (commit_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_commit_valid got %b want 0", commit_valid); end
      resetn = 1'b1;
      repeat (2) @(negedge CLOCK_50);
   endtask

   task automatic test_inc_wrap();
      repeat (3) pressKeys(3'b001, DC + 3, DC + 6);
      testsRun++;
      if (value !== 16'h0003) begin testsFailed++; $display("[TB] FAIL inc3_value got %h want 0003", value); end
      testsRun++;
      if (value !== mValue()) begin testsFailed++; $display("[TB] FAIL inc3_model got %h want %h", value, mValue()); end
      repeat (16) pressKeys(3'b001, DC + 3, DC + 6);
      testsRun++;
      if (value !== 16'h0003) begin testsFailed++; $display("[TB] FAIL inc_wrap_value got %h want 0003", value); end
   endtask

   task automatic test_next();
      applyReset();
      pressKeys(3'b010, DC + 3, DC + 6);
      repeat (2) pressKeys(3'b001, DC + 3, DC + 6);
      testsRun++;
      if (value !== 16'h0020) begin testsFailed++; $display("[TB] FAIL next_inc_value got %h want 0020", value); end
      testsRun++;
      if (cursor !== 2'd1) begin testsFailed++; $display("[TB] FAIL next_cursor got %0d want 1", cursor); end
      repeat (3) pressKeys(3'b010, DC + 3, DC + 6);
      testsRun++;
      if (cursor !== 2'd0) begin testsFailed++; $display("[TB] FAIL cursor_wrap got %0d want 0", cursor); end
   endtask

   task automatic test_glitch_and_latency();
      pressKeys(3'b001, 3, DC + 6);
      testsRun++;
      if (value !== 16'h0020) begin testsFailed++; $display("[TB] FAIL glitch_value got %h want 0020", value); end
      @(negedge CLOCK_50);
      btnIncN = 1'b0;
      repeat (DC + 2) @(negedge CLOCK_50);
      testsRun++;
      if (value !== 16'h0020) begin testsFailed++; $display("[TB] FAIL latency_early got %h want 0020", value); end
      @(negedge CLOCK_50);
      testsRun++;
      if (value !== 16'h0021) begin testsFailed++; $display("[TB] FAIL latency_ontime got %h want 0021", value); end
      repeat (50 - (DC + 3)) @(negedge CLOCK_50);
      btnIncN = 1'b1;
      repeat (DC + 8) @(negedge CLOCK_50);
      testsRun++;
      if (value !== 16'h0021) begin testsFailed++; $display("[TB] FAIL held_once got %h want 0021", value); end
   endtask

   task automatic test_simultaneous();
      int pulses;
      bit prevCv;
      bit doubleCv;
      applyReset();
      repeat (5) pressKeys(3'b001, DC + 3, DC + 6);
      pressKeys(3'b010, DC + 3, DC + 6);
      repeat (10) pressKeys(3'b001, DC + 3, DC + 6);
      repeat (3) pressKeys(3'b010, DC + 3, DC + 6);
      testsRun++;
      if (value !== 16'h00A5 || cursor !== 2'd0) begin
         testsFailed++; $display("[TB] FAIL setup_a5 got %h/%0d want 00A5/0", value, cursor);
      end
      pulses = 0; prevCv = 1'b0; doubleCv = 1'b0;
      @(negedge CLOCK_50);
      btnIncN = 1'b0; btnCommitN = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLOCK_50);
         if (i == DC + 3) begin btnIncN = 1'b1; btnCommitN = 1'b1; end
         if (commit_valid === 1'b1) pulses++;
         if (prevCv && commit_valid === 1'b1) doubleCv = 1'b1;
         prevCv = (commit_valid === 1'b1);
      end
      testsRun++;
      if (committed !== 16'h00A5) begin testsFailed++; $display("[TB] FAIL simul_committed got %h want 00A5", committed); end
      testsRun++;
      if (value !== 16'h00A6) begin testsFailed++; $display("[TB] FAIL simul_value got %h want 00A6", value); end
      testsRun++;
      if (pulses != 1 || doubleCv) begin
         testsFailed++; $display("[TB] FAIL commit_valid_pulses got %0d (double=%0d) want 1", pulses, doubleCv);
      end
   endtask

   task automatic test_blink();
      for (int i = 0; i < 20 && blank === 4'b0000; i++) @(negedge CLOCK_50);
      testsRun++;
      if (blank !== 4'b0001) begin testsFailed++; $display("[TB] FAIL blink_on got %b want 0001", blank); end
      btnNextN = 1'b0;
      for (int i = 0; i < 20 && cursor !== 2'd1; i++) @(negedge CLOCK_50);
      testsRun++;
      if (cursor !== 2'd1 || blank !== 4'b0000) begin
         testsFailed++; $display("[TB] FAIL blink_clear got %0d/%b want 1/0000", cursor, blank);
      end
      repeat (7) @(negedge CLOCK_50);
      testsRun++;
      if (blank !== 4'b0000) begin testsFailed++; $display("[TB] FAIL blink_still_off got %b want 0000", blank); end
      @(negedge CLOCK_50);
      testsRun++;
      if (blank !== 4'b0010) begin testsFailed++; $display("[TB] FAIL blink_toggle got %b want 0010", blank); end
      repeat (8) @(negedge CLOCK_50);
      testsRun++;
      if (blank !== 4'b0000) begin testsFailed++; $display("[TB] FAIL blink_back got %b want 0000", blank); end
      btnNextN = 1'b1;
      repeat (DC + 6) @(negedge CLOCK_50);
   endtask

   task automatic test_reset_mid_debounce();
      @(negedge CLOCK_50);
      btnIncN = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      btnIncN = 1'b1;
      #2 resetn = 1'b0;
      @(negedge CLOCK_50);
      testsRun++;
      if ({value, committed, cursor, blank, commit_valid} !== 39'd0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_clear got %h %h %0d %b %b want all zero", value, committed, cursor, blank, commit_valid);
      end
      resetn = 1'b1;
      repeat (15) @(negedge CLOCK_50);
      testsRun++;
      if (value !== 16'h0000) begin testsFailed++; $display("[TB] FAIL midreset_noevent got %h want 0000", value); end
      btnIncN = 1'b0;
      resetn = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      resetn = 1'b1;
      repeat (DC + 6) @(negedge CLOCK_50);
      btnIncN = 1'b1;
      repeat (DC + 6) @(negedge CLOCK_50);
      testsRun++;
      if (value !== 16'h0001) begin testsFailed++; $display("[TB] FAIL held_through_reset got %h want 0001", value); end
   endtask

   task automatic test_random();
      logic [2:0] mask;
      int hold;
      int gap;
      applyReset();
      for (int s = 0; s < 80; s++) begin
         mask = 3'($urandom_range(1, 7));
         hold = $urandom_range(1, 12);
         gap  = $urandom_range(0, 12);
         @(negedge CLOCK_50);
         if (mask[0]) btnIncN = 1'b0;
         if (mask[1]) btnNextN = 1'b0;
         if (mask[2]) btnCommitN = 1'b0;
         for (int c = 0; c < hold + gap; c++) begin
            @(negedge CLOCK_50);
            if (c == hold - 1) begin btnIncN = 1'b1; btnNextN = 1'b1; btnCommitN = 1'b1; end
            testsRun++;
            if ({value, cursor, blank, committed, commit_valid} !==
                {mValue(), 2'(mCursor), mBlank(), 16'(mCommitted), mCommitValid}) begin
               testsFailed++;
               $display("[TB] FAIL random_slot%0d got v=%h c=%0d b=%b cm=%h cv=%b want v=%h c=%0d b=%b cm=%h cv=%b",
                        s, value, cursor, blank, committed, commit_valid,
                        mValue(), mCursor, mBlank(), 16'(mCommitted), mCommitValid);
            end
         end
      end
   endtask

   initial begin
      resetn = 1'b0;
      btnIncN = 1'b1; btnNextN = 1'b1; btnCommitN = 1'b1;
      test_reset();
      test_inc_wrap();
      test_next();
      test_glitch_and_latency();
      test_simultaneous();
      test_blink();
      test_reset_mid_debounce();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/hex_entry.md
# hex_entry

Front-panel digit entry unit: the input-side counterpart of the counter-to-seven-segment display path. Three raw active-low push-buttons are synchronized and debounced, then used to edit a 4-digit hex value one nibble at a time. The unit publishes the value being edited and a blink mask that downstream `hex_display` instances use to flash the selected digit. It also provides a committed copy of the value with a one-cycle valid strobe, for use by a loadable counter or register.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable samples needed to accept a button level (20 ms at 50 MHz); minimum 2.
- `BLINK_CYCLES`, 12_500_000: clock cycles per blink half-period; minimum 2.
- `CLOCK_50`  in  1  system clock; every register is clocked on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `btn_next_n`  in  1  raw button, active-low; moves the cursor to the next digit.
- `btn_inc_n`  in  1  raw button, active-low; increments the digit under the cursor.
- `btn_commit_n`  in  1  raw button, active-low; publishes the edited value.
- `value`  out  16  value being edited (digit 3 = [15:12] … digit 0 = [3:0]).
- `cursor`  out  2  index of the selected digit.
- `blank`  out  4  per-digit blank mask; only bit `cursor` can be set.
- `committed`  out  16  last committed value.
- `commit_valid`  out  1  one-cycle pulse, asserted in the cycle `committed` updates.

## Operation
- Reset values: `value`=0, `committed`=0, `commit_valid`=0, `cursor`=0, `blank`=0, blink counter and phase cleared, every debouncer in RELEASED with its counter at 0.
- Each button passes through a 2-flop synchronizer into a debouncer FSM:
  - RELEASED → PRESS_WAIT when the synced level is 0; the counter clears.
  - PRESS_WAIT → PRESSED when the counter reaches DEBOUNCE_CYCLES−1 with the level still 0. This transition emits a one-cycle press event. If the level returns to 1 first, the FSM goes back to RELEASED.
  - PRESSED → RELEASE_WAIT when the level is 1.
  - RELEASE_WAIT → RELEASED after DEBOUNCE_CYCLES−1 counts with the level still 1. If the level returns to 0 first, the FSM goes back to PRESSED.
- A held button produces exactly one event. There is no auto-repeat.
- Inc event: digit[cursor] ← digit[cursor]+1 mod 16. There is no carry into the neighbouring digit; 0xF wraps to 0x0.
- Next event: `cursor` ← `cursor`+1 mod 4, so the sequence is 0→1→2→3→0.
- Commit event: `committed` ← `value`; `commit_valid` is 1 for that cycle only.
- Simultaneous events in the same cycle are all applied, each using pre-edge state:
  - Commit captures the value from before the inc.
  - Inc edits the digit at the old cursor.
  - Next then advances the cursor.
- Blink:
  - The counter counts 0..BLINK_CYCLES−1 and the phase toggles on wrap.
  - `blank` = phase ? (1 << `cursor`) : 0.
  - Any inc or next event clears both the counter and the phase, so the edited digit is visible at once.
  - Commit does not affect the blink.

## Timing
- Press latency: if the synced input goes low at edge N and stays low, the event fires at edge N+DEBOUNCE_CYCLES−1. The raw-to-synced delay adds 2 edges. `value`, `cursor` or `committed` are registered 1 edge after the event. Total from the first raw sample low to the visible output: DEBOUNCE_CYCLES+2 edges.
- A low glitch shorter than DEBOUNCE_CYCLES synced cycles produces no event.
- The release debounce has the same length. A new press is accepted only after the FSM has returned to RELEASED.
- When `resetn` is asserted mid-debounce, all state clears immediately. A button held through reset release must still complete a full debounce, then fires one event.
- `commit_valid` never stays high for 2 consecutive cycles.

## Structure
- Shared package `hex_entry_pkg` holds:
  - the debouncer state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - `NUM_DIGITS`=4 and `DIGIT_W`=4.
- Sub-module `key_debounce` contains the synchronizer, FSM and counter, and outputs a `press` pulse. It has parameter DEBOUNCE_CYCLES and is instantiated 3 times.
- The top level contains the digit registers, cursor, commit logic and blink generator.
- Segment encoding is not part of this block; the existing hex display decoder is instantiated by the parent.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.
- Reset applied → `value`=0x0000, `committed`=0x0000, `cursor`=0, `blank`=0000, `commit_valid`=0.
- 3 clean inc presses → `value`=0x0003. 16 further presses → `value`=0x0003 (wrap, no carry into digit 1).
- Next, then 2 inc presses → `value`=0x0020 and `cursor`=1. 3 more next presses → `cursor`=0.
- A 3-cycle low glitch on btn_inc_n → no event, `value` unchanged. A held press lasting 50 cycles → exactly one increment, appearing DEBOUNCE_CYCLES+2 edges after the first low sample.
- With `value`=0x00A5, commit and inc fire in the same cycle → `committed`=0x00A5, `value`=0x00A6, `commit_valid` high for exactly 1 cycle.
- `blank` toggles bit `cursor` every 8 cycles and drops to 0 on an inc. A `resetn` pulse during PRESS_WAIT → no event, all outputs back at reset values.
